// File: rtl/vb_mem_arbiter_if.sv
// Bus bundle for vb_mem_arbiter: Wishbone slave pins, core request port and the
// shared byte-wide memory port. The arbiter takes the slave view.
interface vb_mem_arbiter_if #(
    parameter int AW = 16
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;

    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_wdata;
    logic          core_ack;
    logic [7:0]    core_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ready;
    logic [7:0]    mem_rdata;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  core_req, core_we, core_addr, core_wdata,
        input  mem_ready, mem_rdata,
        output wbs_ack_o, wbs_dat_o, core_ack, core_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output core_req, core_we, core_addr, core_wdata,
        output mem_ready, mem_rdata,
        input  wbs_ack_o, wbs_dat_o, core_ack, core_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vb_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between the Wishbone
// slave (32-bit accesses split into per-lane byte accesses) and the vb core.
module vb_mem_arbiter #(
    parameter int          AW        = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    vb_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CORE_ACC,
        CORE_DONE,
        WB_ISSUE,
        WB_WAIT,
        WB_ACK
    } state_t;

    state_t        state;
    logic          last_wb;
    logic [3:0]    sel_rem;
    logic [AW-3:0] wb_word;
    logic [31:0]   wb_dat;
    logic          wb_we;
    logic [1:0]    cur_lane;
    logic          wb_abort;
    logic          wb_valid;
    logic [1:0]    lane;

    function automatic logic [1:0] low_lane(input logic [3:0] s);
        if (s[0])      return 2'd0;
        else if (s[1]) return 2'd1;
        else if (s[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign wb_valid = bus.wbs_cyc_i & bus.wbs_stb_i &
                      (bus.wbs_adr_i[31:AW] == BASE_ADDR[31:AW]);
    assign lane     = low_lane(sel_rem);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            last_wb        <= 1'b1;
            wb_abort       <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.core_ack   <= 1'b0;
            bus.core_rdata <= '0;
            bus.wbs_ack_o  <= 1'b0;
            bus.wbs_dat_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Core wins when alone or when the WB side was served last.
                    if (bus.core_req && (!wb_valid || last_wb)) begin
                        bus.mem_addr  <= bus.core_addr;
                        bus.mem_we    <= bus.core_we;
                        bus.mem_wdata <= bus.core_wdata;
                        bus.mem_req   <= 1'b1;
                        last_wb       <= 1'b0;
                        state         <= CORE_ACC;
                    end else if (wb_valid) begin
                        sel_rem       <= bus.wbs_sel_i;
                        wb_word       <= bus.wbs_adr_i[AW-1:2];
                        wb_dat        <= bus.wbs_dat_i;
                        wb_we         <= bus.wbs_we_i;
                        wb_abort      <= 1'b0;
                        bus.wbs_dat_o <= '0;
                        last_wb       <= 1'b1;
                        state         <= WB_ISSUE;
                    end
                end
                CORE_ACC: begin
                    if (bus.mem_ready) begin
                        bus.mem_req  <= 1'b0;
                        if (!bus.mem_we) bus.core_rdata <= bus.mem_rdata;
                        bus.core_ack <= 1'b1;
                        state        <= CORE_DONE;
                    end
                end
                CORE_DONE: begin
                    bus.core_ack <= 1'b0;
                    state        <= IDLE;
                end
                WB_ISSUE: begin
                    if (!bus.wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (sel_rem == 4'd0) begin
                        bus.wbs_ack_o <= 1'b1;
                        state         <= WB_ACK;
                    end else begin
                        bus.mem_addr  <= {wb_word, lane};
                        bus.mem_we    <= wb_we;
                        bus.mem_wdata <= wb_dat[{lane, 3'b000} +: 8];
                        bus.mem_req   <= 1'b1;
                        cur_lane      <= lane;
                        sel_rem[lane] <= 1'b0;
                        state         <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    // A dropped cycle lets the outstanding byte finish, then abandons the rest.
                    if (!bus.wbs_cyc_i) wb_abort <= 1'b1;
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (!wb_we) bus.wbs_dat_o[{cur_lane, 3'b000} +: 8] <= bus.mem_rdata;
                        if (wb_abort || !bus.wbs_cyc_i) begin
                            state <= IDLE;
                        end else if (sel_rem != 4'd0) begin
                            state <= WB_ISSUE;
                        end else begin
                            bus.wbs_ack_o <= 1'b1;
                            state         <= WB_ACK;
                        end
                    end
                end
                WB_ACK: begin
                    bus.wbs_ack_o <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vb_mem_arbiter.sv
// Bench for vb_mem_arbiter: transaction-level reference memory, expected access
// queues and per-cycle protocol checks, with directed cases and random traffic.
module tb_vb_mem_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vb_mem_arbiter_if #(.AW(AW)) bus ();
    vb_mem_arbiter #(.AW(AW), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } acc_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] phys    [0:65535];
    logic [7:0] ref_mem [0:65535];
    acc_t wb_q[$];
    acc_t acc_log[$];
    int   ack_log[$];
    acc_t core_exp;
    logic core_exp_vld  = 1'b0;
    logic wb_started    = 1'b0;
    logic wb_expect_ack = 1'b0;
    int   mem_dly_max   = 0;
    int   mem_dly_force = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wb_expect(input logic [31:0] adr, input logic [3:0] sel);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++) begin
            logic [1:0] ll = l[1:0];
            if (sel[l]) r[8*l +: 8] = ref_mem[{adr[15:2], ll}];
        end
        return r;
    endfunction

    // Memory responder: ready after a per-access delay, data from phys.
    initial begin
        int   cnt;
        int   dly;
        logic busy;
        cnt = 0; dly = 0; busy = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (bus.mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    dly  = (mem_dly_force >= 0) ? mem_dly_force : $urandom_range(mem_dly_max, 0);
                end
                if (cnt == dly) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        phys[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = 8'($urandom);
                    end else begin
                        bus.mem_rdata = phys[bus.mem_addr];
                    end
                    busy = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Per-cycle compare process.
    initial begin
        logic        prev_req  = 1'b0;
        logic        prev_done = 1'b0;
        logic        prev_cack = 1'b0;
        logic        prev_wack = 1'b0;
        logic [24:0] prev_cmd  = '0;
        acc_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0; prev_done = 1'b0; prev_cack = 1'b0; prev_wack = 1'b0;
                continue;
            end
            if (prev_done)
                check("mem_req gap after access", bus.mem_req, 1'b0);
            else if (prev_req && bus.mem_req)
                check("mem cmd stable", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, prev_cmd);
            if (bus.mem_req && bus.mem_ready) begin
                acc_log.push_back({bus.mem_addr, bus.mem_we, bus.mem_wdata});
                if (bus.mem_addr >= 16'h0100) begin
                    check("core access inside wb sequence", wb_started, 1'b0);
                    check("core access expected", core_exp_vld, 1'b1);
                    if (core_exp_vld) begin
                        check("core mem addr/we", {bus.mem_addr, bus.mem_we}, {core_exp.addr, core_exp.we});
                        if (core_exp.we) check("core mem wdata", bus.mem_wdata, core_exp.data);
                    end
                    core_exp_vld = 1'b0;
                end else if (wb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wb access unexpected: addr %h we %b", bus.mem_addr, bus.mem_we);
                end else begin
                    e = wb_q.pop_front();
                    check("wb mem addr/we", {bus.mem_addr, bus.mem_we}, {e.addr, e.we});
                    if (e.we) check("wb mem wdata", bus.mem_wdata, e.data);
                    wb_started = (wb_q.size() != 0);
                end
            end
            if (bus.core_ack) begin
                ack_log.push_back(0);
                check("core_ack single pulse", prev_cack, 1'b0);
            end
            if (bus.wbs_ack_o) begin
                ack_log.push_back(1);
                check("wbs_ack single pulse", prev_wack, 1'b0);
                check("wbs_ack only when claimed", wb_expect_ack, 1'b1);
            end
            prev_done = bus.mem_req & bus.mem_ready;
            prev_req  = bus.mem_req;
            prev_cmd  = {bus.mem_addr, bus.mem_we, bus.mem_wdata};
            prev_cack = bus.core_ack;
            prev_wack = bus.wbs_ack_o;
        end
    end

    task automatic core_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
        core_exp       = {addr, we, wd};
        core_exp_vld   = 1'b1;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wd;
        bus.core_req   = 1'b1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (bus.core_ack) break;
        end
        check("core_ack within budget", bus.core_ack, 1'b1);
        rd = bus.core_rdata;
        @(posedge clk); #1;
        bus.core_req = 1'b0;
        if (we) ref_mem[addr] = wd;
        else    check("core read data", rd, ref_mem[addr]);
    endtask

    task automatic wb_txn(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat, input int budget,
                          output logic [31:0] rd, output logic acked, output int lat);
        logic claimed = (adr[31:16] == 16'h3000);
        acc_t e;
        if (claimed) begin
            for (int l = 0; l < 4; l++) begin
                logic [1:0] ll = l[1:0];
                if (sel[l]) begin
                    e.addr = {adr[15:2], ll};
                    e.we   = we;
                    e.data = dat[8*l +: 8];
                    wb_q.push_back(e);
                end
            end
        end
        wb_expect_ack = claimed;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = sel;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        lat = 0; acked = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (bus.wbs_ack_o) begin acked = 1'b1; break; end
        end
        rd = bus.wbs_dat_o;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        wb_expect_ack = 1'b0;
        if (acked) begin
            if (we) begin
                for (int l = 0; l < 4; l++) begin
                    logic [1:0] ll = l[1:0];
                    if (sel[l]) ref_mem[{adr[15:2], ll}] = dat[8*l +: 8];
                end
            end else begin
                check("wb read data", rd, wb_expect(adr, sel));
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " mem_req"},    bus.mem_req,    1'b0);
        check({tag, " mem_we"},     bus.mem_we,     1'b0);
        check({tag, " mem_addr"},   bus.mem_addr,   16'h0);
        check({tag, " mem_wdata"},  bus.mem_wdata,  8'h0);
        check({tag, " core_ack"},   bus.core_ack,   1'b0);
        check({tag, " core_rdata"}, bus.core_rdata, 8'h0);
        check({tag, " wbs_ack_o"},  bus.wbs_ack_o,  1'b0);
        check({tag, " wbs_dat_o"},  bus.wbs_dat_o,  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd8;
        logic [31:0] rd32;
        logic        acked;
        logic        got;
        int          lat;
        int          n0;
        logic [7:0]  beef [4];
        acc_t        e;
        beef[0] = 8'hEF; beef[1] = 8'hBE; beef[2] = 8'hAD; beef[3] = 8'hDE;

        for (int i = 0; i < 65536; i++) begin
            logic [7:0] v = 8'($urandom);
            phys[i] = v;
            ref_mem[i] = v;
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Core write then read-back
        core_txn(1'b1, 16'h0123, 8'hA5, rd8, lat);
        check("core write latency", lat, 3);
        e = acc_log[acc_log.size()-1];
        check("core write access", e, {16'h0123, 1'b1, 8'hA5});
        core_txn(1'b0, 16'h0123, 8'h00, rd8, lat);
        check("core read-back value", rd8, 8'hA5);
        check("core read latency", lat, 3);

        // WB full-word write
        n0 = acc_log.size();
        wb_txn(32'h3000_0010, 4'hF, 1'b1, 32'hDEADBEEF, 50, rd32, acked, lat);
        check("wb word write acked", acked, 1'b1);
        check("wb word write latency", lat, 10);
        check("wb word write access count", acc_log.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            e = acc_log[n0 + i];
            check("wb word write lane", e, {16'h0010 + 16'(i), 1'b1, beef[i]});
        end

        // WB sparse read
        n0 = acc_log.size();
        wb_txn(32'h3000_0010, 4'b1010, 1'b0, 32'h0, 50, rd32, acked, lat);
        check("wb sparse read acked", acked, 1'b1);
        check("wb sparse read data", rd32, 32'hDE00BE00);
        check("wb sparse read latency", lat, 6);
        check("wb sparse access count", acc_log.size() - n0, 2);
        e = acc_log[n0];     check("wb sparse first addr", e.addr, 16'h0011);
        e = acc_log[n0 + 1]; check("wb sparse second addr", e.addr, 16'h0013);

        // sel = 0
        n0 = acc_log.size();
        wb_txn(32'h3000_0020, 4'h0, 1'b0, 32'h0, 50, rd32, acked, lat);
        check("wb sel0 acked", acked, 1'b1);
        check("wb sel0 latency", lat, 3);
        check("wb sel0 no access", acc_log.size() - n0, 0);
        check("wb sel0 data", rd32, 32'h0);

        // Unclaimed address
        n0 = acc_log.size();
        wb_txn(32'h2000_0000, 4'hF, 1'b1, 32'h12345678, 20, rd32, acked, lat);
        check("unclaimed not acked", acked, 1'b0);
        check("unclaimed no access", acc_log.size() - n0, 0);

        // Cycle dropped after lane 0
        n0 = acc_log.size();
        wb_q.push_back({16'h0040, 1'b1, 8'h44});
        wb_expect_ack = 1'b0;
        bus.wbs_adr_i = 32'h3000_0040; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b1;
        bus.wbs_dat_i = 32'h11223344;  bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_ready) begin got = 1'b1; break; end
        end
        check("abort lane0 issued", got, 1'b1);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        ref_mem[16'h0040] = 8'h44;
        repeat (10) @(posedge clk);
        #1;
        check("abort only one access", acc_log.size() - n0, 1);
        wb_q.delete(); wb_started = 1'b0;
        core_txn(1'b0, 16'h0123, 8'h00, rd8, lat);
        check("after abort core latency", lat, 3);
        wb_txn(32'h3000_0040, 4'hF, 1'b0, 32'h0, 50, rd32, acked, lat);
        check("after abort lane0 written", rd32[7:0], 8'h44);

        // Reset while a WB lane waits on memory
        mem_dly_force = 20;
        wb_q.push_back({16'h0050, 1'b1, 8'h5A});
        bus.wbs_adr_i = 32'h3000_0050; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b1;
        bus.wbs_dat_i = 32'hC3B2A15A;  bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin got = 1'b1; break; end
        end
        check("reset test mem_req seen", got, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wb_q.delete(); wb_started = 1'b0; mem_dly_force = -1;
        @(negedge clk);
        check_outputs_zero("mid-access reset");
        @(posedge clk); #1;
        core_txn(1'b1, 16'h0150, 8'h3C, rd8, lat);
        check("post-reset core latency", lat, 3);
        core_txn(1'b0, 16'h0150, 8'h00, rd8, lat);
        check("post-reset core read", rd8, 8'h3C);

        // Contention from reset
        rst = 1'b1;
        ack_log.delete();
        fork
            begin
                logic [7:0] r;
                int         l;
                for (int i = 0; i < 2; i++) core_txn(1'b1, 16'h0200 + 16'(i), 8'($urandom), r, l);
            end
            begin
                logic [31:0] r;
                logic        a;
                int          l;
                for (int i = 0; i < 2; i++) begin
                    wb_txn(32'h3000_0080 + 32'(4*i), 4'hF, 1'b1, $urandom, 200, r, a, l);
                    check("contention wb acked", a, 1'b1);
                end
            end
            begin
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        check("contention ack count", ack_log.size(), 4);
        if (ack_log.size() >= 4)
            for (int i = 0; i < 4; i++) check("contention grant order", ack_log[i], i % 2);

        // Random concurrent traffic on disjoint address ranges
        mem_dly_max = 2;
        fork
            begin
                logic [7:0] r;
                int         l;
                for (int i = 0; i < 40; i++) begin
                    int g = $urandom_range(3, 0);
                    for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
                    core_txn(1'($urandom), 16'h0100 + 16'($urandom_range(255, 0)), 8'($urandom), r, l);
                end
            end
            begin
                logic [31:0] r;
                logic        a;
                int          l;
                for (int i = 0; i < 40; i++) begin
                    int g = $urandom_range(3, 0);
                    for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
                    wb_txn(32'h3000_0000 + 32'(4 * $urandom_range(63, 0)), 4'($urandom),
                           1'($urandom), $urandom, 300, r, a, l);
                    check("random wb acked", a, 1'b1);
                end
            end
        join

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
